mem_access_unit: RTL
====================

# mem_access_unit

Load/store sequencer between the execute stage and `data_mem`. It accepts one word-sized load or store per request, then checks alignment and range. It drives `data_mem` through its registered-address protocol: the address goes out first, and the write or read happens one cycle later. It returns a single-cycle response with load data or an error flag to the writeback stage.

## Interface
Parameters:
- `ADDR_W`, 5: word-address width; must match `data_mem` (32 words).
- `DATA_W`, 32: data width.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: unit can accept a request this cycle.
- `req_store`  in  1: 1 = store, 0 = load.
- `req_addr`  in  32: byte address.
- `req_wdata`  in  DATA_W: store data.
- `resp_valid`  out  1: one-cycle completion pulse; there is no backpressure.
- `resp_rdata`  out  DATA_W: load data. It is 0 for stores and for errors.
- `resp_err`  out  1: the request was misaligned or out of range.
- `mem_wren`  out  1: `data_mem` write enable, active-low (0 = write).
- `mem_is_store`  out  1: current access is a store.
- `mem_r_addr`  out  ADDR_W: word address to `data_mem`.
- `mem_w_addr`  out  ADDR_W: word address to `data_mem`. It is always equal to `mem_r_addr`.
- `mem_w_data`  out  DATA_W: store data to `data_mem`.
- `mem_r_data`  in  DATA_W: read data from `data_mem`, addressed by its registered address.

## Operation
- Request fields are captured into `op_q`, `addr_q` (word address = `req_addr[ADDR_W+1:2]`) and `wdata_q`.
- States:
  - IDLE: `req_ready`=1.
  - SETUP: `mem_r_addr`=`addr_q`, `mem_wren`=1.
  - ACCESS: `mem_r_addr` is held at `addr_q`.
    - Store: `mem_wren`=0 and `mem_w_data`=`wdata_q`.
    - Load: `mem_r_data` is captured into `resp_rdata` at the end of the cycle.
  - RESP: `resp_valid`=1, `req_ready`=1.
  - ERR: `resp_valid`=1, `resp_err`=1, `req_ready`=1. No memory access is made.
- Acceptance is `req_valid && req_ready`, in IDLE or RESP/ERR.
  - Error if `req_addr[1:0]`≠0 (misaligned) or `req_addr[31:ADDR_W+2]`≠0 (out of range). Next state is ERR.
  - Otherwise next state is SETUP.
- RESP or ERR with no new acceptance: next state is IDLE.
- `mem_*` outputs are decoded combinationally from registered state only. There is no combinational path from `req_*` to `mem_*`.
- `mem_is_store`=`op_q` in SETUP and ACCESS, and 0 elsewhere.
- Outside SETUP and ACCESS, `mem_r_addr`/`mem_w_addr` hold their last value.
- `resp_rdata`, `resp_err` and `resp_valid` are registered.
- `resp_rdata` is zeroed when a store or error response is issued. It holds its value between responses.

## Timing
- Reset values: state IDLE; `req_ready`=1; `resp_valid`=0, `resp_err`=0, `resp_rdata`=0; `mem_wren`=1, `mem_is_store`=0; `mem_r_addr`=`mem_w_addr`=0; `mem_w_data`=0.
- Valid request accepted at edge E:
  - SETUP in cycle E+1.
  - ACCESS in cycle E+2; a store is written at edge E+3.
  - `resp_valid` high in cycle E+3.
- Error request accepted at edge E: `resp_valid`/`resp_err` high in cycle E+1.
- Throughput: one valid request per 3 cycles, since acceptance is allowed in RESP. Errors can be accepted back-to-back, one per cycle.
- `rst` asserted in any state: next state is IDLE, and the response is dropped.
  - Exception: a store whose ACCESS cycle coincides with `rst` is still written at that edge, because `data_mem` has no reset.
  - `rst` and `req_valid` in the same cycle: the request is ignored.
- Word address wrap: none. Any byte address above 0x7C is an error.

## Test plan
- Store 0xDEADBEEF @0x10, then load @0x10:
  - `mem_wren`=0 exactly one cycle, with `mem_r_addr`=4.
  - Load response 3 cycles after accept, with `resp_rdata`=0xDEADBEEF and `resp_err`=0.
- Load @0x7C after store 0x12345678 @0x7C: `mem_r_addr`=31, `resp_rdata`=0x12345678.
- Load @0x06 and store @0x80: each gets `resp_err`=1 one cycle after accept. `mem_wren` stays 1 and `mem_is_store` stays 0.
- `req_valid` held high with three stores to 0x00, 0x04, 0x08:
  - Accepts at cycles 0, 3, 6.
  - `resp_valid` at cycles 3, 6, 9.
  - A readback returns all three values.
- `rst` during SETUP of a store of 0xAAAA5555 @0x20: no write (`mem_wren` never 0), no `resp_valid`, and all outputs at reset values next cycle.
- `rst` during ACCESS of a store of 0x0BADF00D @0x24: no response; a later load @0x24 returns 0x0BADF00D.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Load/store sequencer between the execute stage and data_mem. Takes one
// word-sized load or store per request and checks alignment and range. It
// drives data_mem through its registered-address protocol (address out in
// SETUP, access in ACCESS) and returns a single-cycle response.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake
//   req_store                 1 = store, 0 = load
//   req_addr                  byte address
//   req_wdata                 store data
//   resp_valid                one-cycle completion pulse (no backpressure)
//   resp_rdata                load data, 0 for stores and errors
//   resp_err                  misaligned or out-of-range request
//   mem_wren                  data_mem write enable, active low
//   mem_is_store              current access is a store
//   mem_r_addr / mem_w_addr   word address to data_mem (always equal)
//   mem_w_data                store data to data_mem
//   mem_r_data                read data from data_mem
module mem_access_unit #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_wren,
    output logic              mem_is_store,
    output logic [ADDR_W-1:0] mem_r_addr,
    output logic [ADDR_W-1:0] mem_w_addr,
    output logic [DATA_W-1:0] mem_w_data,
    input  logic [DATA_W-1:0] mem_r_data
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        RESP   = 3'd3,
        ERR    = 3'd4
    } state_t;

    state_t              state;
    logic                op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                accept;
    logic                req_bad;

    // Ready is a pure decode of the state register: a new request may be
    // taken while idle or while the previous response is on the bus.
    assign req_ready = (state == IDLE) || (state == RESP) || (state == ERR);
    assign accept    = req_valid && req_ready;

    assign req_bad = (req_addr[1:0] != 2'b00) ||
                     (req_addr[31:ADDR_W+2] != '0);

    // addr_q / wdata_q only load on a good request, so outside SETUP and
    // ACCESS the memory address naturally holds its last value and an
    // error request never disturbs the memory port.
    assign mem_r_addr   = addr_q;
    assign mem_w_addr   = addr_q;
    assign mem_w_data   = wdata_q;
    assign mem_is_store = op_q && ((state == SETUP) || (state == ACCESS));
    assign mem_wren     = !(op_q && (state == ACCESS));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;

            case (state)
                SETUP:  state <= ACCESS;
                ACCESS: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    // data_mem presents the word during ACCESS
                    resp_rdata <= op_q ? '0 : mem_r_data;
                end
                default: state <= IDLE;
            endcase

            // accept is only possible in IDLE/RESP/ERR, so it never
            // collides with the ACCESS branch above.
            if (accept) begin
                if (req_bad) begin
                    state      <= ERR;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b1;
                    resp_rdata <= '0;
                end else begin
                    state   <= SETUP;
                    op_q    <= req_store;
                    addr_q  <= req_addr[ADDR_W+1:2];
                    wdata_q <= req_wdata;
                end
            end
        end
    end

endmodule
